// File: rtl/vec_issue_ctrl_if.sv
// Issue-control bundle: instruction queue head, unit status, writeback and issue outputs.
// Signal names mirror the controller's port list; master is the queue/unit side, slave the controller.
interface vec_issue_ctrl_if #(
  parameter int NUM_REGS   = 32,
  parameter int MVL        = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int VW  = $clog2(NUM_REGS);
  localparam int VLW = $clog2(MVL) + 1;

  logic                  q_empty;
  logic                  setvl;
  logic                  load;
  logic                  store;
  logic                  iload;
  logic                  istore;
  logic                  alu_op;
  logic                  masked_op;
  logic [1:0]            esc;
  logic [VW-1:0]         src1;
  logic [VW-1:0]         src2;
  logic [VW-1:0]         dst;
  logic [DATA_WIDTH-1:0] vl_src;
  logic                  alu_busy;
  logic                  mem_busy;
  logic                  wb_valid;
  logic [VW-1:0]         wb_dst;

  logic                  stalling;
  logic                  alu_issue;
  logic                  mem_issue;
  logic [VW-1:0]         iss_src1;
  logic [VW-1:0]         iss_src2;
  logic [VW-1:0]         iss_dst;
  logic                  iss_masked;
  logic [VLW-1:0]        vl;
  logic [NUM_REGS-1:0]   sb_busy;
  logic [1:0]            dbg_state;

  // Handshake: the head is consumed in any cycle where q_empty=0 and stalling=0;
  // alu_issue/mem_issue are one-cycle pulses accepted unconditionally by a non-busy unit.
  modport master (
    output q_empty, setvl, load, store, iload, istore, alu_op, masked_op, esc,
           src1, src2, dst, vl_src, alu_busy, mem_busy, wb_valid, wb_dst,
    input  stalling, alu_issue, mem_issue, iss_src1, iss_src2, iss_dst, iss_masked,
           vl, sb_busy, dbg_state
  );

  modport slave (
    input  q_empty, setvl, load, store, iload, istore, alu_op, masked_op, esc,
           src1, src2, dst, vl_src, alu_busy, mem_busy, wb_valid, wb_dst,
    output stalling, alu_issue, mem_issue, iss_src1, iss_src2, iss_dst, iss_masked,
           vl, sb_busy, dbg_state
  );
endinterface

// File: rtl/vec_issue_ctrl.sv
// Vector issue controller: scoreboarded in-order issue to ALU/memory units plus setvl drain FSM.
// Optional macro VEC_ISSUE_WB_BYPASS_EN lets a same-cycle writeback clear a hazard.
module vec_issue_ctrl #(
  parameter int NUM_REGS   = 32,
  parameter int MVL        = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  vec_issue_ctrl_if.slave bus
);
  localparam int VLW = $clog2(MVL) + 1;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SETVL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic [VLW-1:0]      vl_q, vl_d;

  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] hz_view;
  logic                is_mem, is_alu, is_nop, writes_dst;
  logic                hazard, head_ok;
  logic                fire_alu, fire_mem, nop_take, consume;

  always_comb begin
    wb_mask = bus.wb_valid ? (NUM_REGS'(1) << bus.wb_dst) : '0;
`ifdef VEC_ISSUE_WB_BYPASS_EN
    hz_view = sb_q & ~wb_mask;
`else
    hz_view = sb_q;
`endif
    is_mem     = bus.load | bus.iload | bus.store | bus.istore;
    is_alu     = ~is_mem & bus.alu_op;
    is_nop     = ~(bus.setvl | is_mem | bus.alu_op);
    writes_dst = bus.load | bus.iload | is_alu;

    // dst is always checked: covers WAW and the data register of a store
    hazard = (~bus.esc[0] & hz_view[bus.src1]) |
             (~bus.esc[1] & hz_view[bus.src2]) |
             (bus.masked_op & hz_view[0]) |
             hz_view[bus.dst];

    head_ok  = rst & (state_q == ST_ISSUE) & ~bus.q_empty & ~bus.setvl;
    fire_mem = head_ok & is_mem & ~hazard & ~bus.mem_busy;
    fire_alu = head_ok & is_alu & ~hazard & ~bus.alu_busy;
    nop_take = head_ok & is_nop;
    consume  = fire_alu | fire_mem | nop_take | (rst & (state_q == ST_SETVL));
  end

  always_comb begin
    sb_d    = sb_q & ~wb_mask;
    // applied after the clear so a same-cycle set on the same bit wins
    if ((fire_alu | fire_mem) & writes_dst) sb_d[bus.dst] = 1'b1;

    state_d = state_q;
    vl_d    = vl_q;
    case (state_q)
      ST_ISSUE: if (~bus.q_empty & bus.setvl) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (bus.q_empty)                                            state_d = ST_ISSUE;
        else if ((sb_q == '0) & ~bus.alu_busy & ~bus.mem_busy)      state_d = ST_SETVL;
      end
      ST_SETVL: begin
        vl_d    = (bus.vl_src > DATA_WIDTH'(MVL)) ? VLW'(MVL) : VLW'(bus.vl_src);
        state_d = ST_ISSUE;
      end
      default:  state_d = ST_ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ISSUE;
      sb_q    <= '0;
      vl_q    <= VLW'(MVL);
    end else begin
      state_q <= state_d;
      sb_q    <= sb_d;
      vl_q    <= vl_d;
    end
  end

  assign bus.stalling   = rst & ~bus.q_empty & ~consume;
  assign bus.alu_issue  = fire_alu;
  assign bus.mem_issue  = fire_mem;
  assign bus.iss_src1   = (fire_alu | fire_mem) ? bus.src1 : '0;
  assign bus.iss_src2   = (fire_alu | fire_mem) ? bus.src2 : '0;
  assign bus.iss_dst    = (fire_alu | fire_mem) ? bus.dst  : '0;
  assign bus.iss_masked = (fire_alu | fire_mem) & bus.masked_op;
  assign bus.vl         = vl_q;
  assign bus.sb_busy    = sb_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Directed bench for vec_issue_ctrl: reset, RAW chain, store, set/clear race, structural stall, setvl.
module tb_vec_issue_ctrl;
  localparam int VW = 5;
  localparam logic [6:0] C_NOP   = 7'b0000000;
  localparam logic [6:0] C_ALU   = 7'b0000010;
  localparam logic [6:0] C_MALU  = 7'b0000011;
  localparam logic [6:0] C_STORE = 7'b0010000;
  localparam logic [6:0] C_LOAD  = 7'b0100000;
  localparam logic [6:0] C_SETVL = 7'b1000000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  vec_issue_ctrl_if #(.NUM_REGS(32), .MVL(32), .DATA_WIDTH(32)) bus();
  vec_issue_ctrl #(.NUM_REGS(32), .MVL(32), .DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle();
    bus.q_empty = 1'b1; bus.setvl = 1'b0; bus.load = 1'b0; bus.store = 1'b0;
    bus.iload = 1'b0; bus.istore = 1'b0; bus.alu_op = 1'b0; bus.masked_op = 1'b0;
    bus.esc = 2'b00; bus.src1 = '0; bus.src2 = '0; bus.dst = '0; bus.vl_src = '0;
    bus.alu_busy = 1'b0; bus.mem_busy = 1'b0; bus.wb_valid = 1'b0; bus.wb_dst = '0;
  endtask

  task automatic drive_head(input logic [6:0] cls, input logic [1:0] e, input int s1, input int s2, input int d);
    bus.q_empty = 1'b0;
    {bus.setvl, bus.load, bus.store, bus.iload, bus.istore, bus.alu_op, bus.masked_op} = cls;
    bus.esc = e; bus.src1 = VW'(s1); bus.src2 = VW'(s2); bus.dst = VW'(d);
  endtask

  task automatic writeback(input int r);
    @(negedge clk); idle(); bus.wb_valid = 1'b1; bus.wb_dst = VW'(r);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {bus.setvl, bus.load, bus.store, bus.iload, bus.istore, bus.alu_op, bus.masked_op} = 7'($urandom_range(0, 127));
      bus.q_empty = 1'($urandom_range(0, 1)); bus.esc = 2'($urandom_range(0, 3));
      bus.src1 = VW'($urandom_range(0, 31)); bus.src2 = VW'($urandom_range(0, 31));
      bus.dst = VW'($urandom_range(0, 31)); bus.vl_src = 32'($urandom_range(0, 200));
      bus.wb_valid = 1'($urandom_range(0, 1)); bus.wb_dst = VW'($urandom_range(0, 31));
      bus.alu_busy = 1'($urandom_range(0, 1)); bus.mem_busy = 1'($urandom_range(0, 1));
      #1;
      n_checks++; if (bus.stalling !== 1'b0) begin n_fail++; $display("FAIL reset_stalling: got %b want 0", bus.stalling); end
      n_checks++; if ({bus.alu_issue, bus.mem_issue} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {bus.alu_issue, bus.mem_issue}); end
      n_checks++; if ({bus.iss_src1, bus.iss_src2, bus.iss_dst, bus.iss_masked} !== 16'h0) begin n_fail++; $display("FAIL reset_iss: got %h want 0", {bus.iss_src1, bus.iss_src2, bus.iss_dst, bus.iss_masked}); end
      @(posedge clk); #1;
      n_checks++; if (bus.sb_busy !== 32'h0) begin n_fail++; $display("FAIL reset_sb: got %h want 0", bus.sb_busy); end
      n_checks++; if (bus.vl !== 6'd32) begin n_fail++; $display("FAIL reset_vl: got %0d want 32", bus.vl); end
    end
    @(negedge clk); idle(); rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.dbg_state !== 2'd0) begin n_fail++; $display("FAIL post_reset_state: got %0d want 0", bus.dbg_state); end
    n_checks++; if (bus.vl !== 6'd32) begin n_fail++; $display("FAIL post_reset_vl: got %0d want 32", bus.vl); end
  endtask

  task automatic test_raw_chain();
    @(negedge clk); idle(); drive_head(C_ALU, 2'b00, 1, 2, 3); #1;
    n_checks++; if (bus.alu_issue !== 1'b1) begin n_fail++; $display("FAIL raw_first_issue: got %b want 1", bus.alu_issue); end
    n_checks++; if ({bus.iss_src1, bus.iss_src2, bus.iss_dst} !== {5'd1, 5'd2, 5'd3}) begin n_fail++; $display("FAIL raw_first_iss: got %h want %h", {bus.iss_src1, bus.iss_src2, bus.iss_dst}, {5'd1, 5'd2, 5'd3}); end
    @(posedge clk); #1;
    n_checks++; if (bus.sb_busy !== 32'h8) begin n_fail++; $display("FAIL raw_sb_set3: got %h want 8", bus.sb_busy); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); drive_head(C_ALU, 2'b00, 3, 2, 4); #1;
      n_checks++; if ({bus.stalling, bus.alu_issue} !== 2'b10) begin n_fail++; $display("FAIL raw_hold: got %b want 10", {bus.stalling, bus.alu_issue}); end
      @(posedge clk);
    end
    @(negedge clk); bus.wb_valid = 1'b1; bus.wb_dst = 5'd3; #1;
`ifdef VEC_ISSUE_WB_BYPASS_EN
    n_checks++; if ({bus.stalling, bus.alu_issue} !== 2'b01) begin n_fail++; $display("FAIL raw_wb_cycle: got %b want 01", {bus.stalling, bus.alu_issue}); end
    @(posedge clk); #1;
`else
    n_checks++; if ({bus.stalling, bus.alu_issue} !== 2'b10) begin n_fail++; $display("FAIL raw_wb_cycle: got %b want 10", {bus.stalling, bus.alu_issue}); end
    @(posedge clk); #1;
    n_checks++; if (bus.sb_busy !== 32'h0) begin n_fail++; $display("FAIL raw_sb_clr3: got %h want 0", bus.sb_busy); end
    @(negedge clk); bus.wb_valid = 1'b0; #1;
    n_checks++; if ({bus.stalling, bus.alu_issue} !== 2'b01) begin n_fail++; $display("FAIL raw_after_wb: got %b want 01", {bus.stalling, bus.alu_issue}); end
    @(posedge clk); #1;
`endif
    n_checks++; if (bus.sb_busy !== 32'h10) begin n_fail++; $display("FAIL raw_sb_set4: got %h want 10", bus.sb_busy); end
    writeback(4);
    n_checks++; if (bus.sb_busy !== 32'h0) begin n_fail++; $display("FAIL raw_cleanup: got %h want 0", bus.sb_busy); end
  endtask

  task automatic test_store();
    @(negedge clk); idle(); drive_head(C_STORE, 2'b11, 0, 0, 5); #1;
    n_checks++; if ({bus.mem_issue, bus.alu_issue, bus.iss_dst} !== {2'b10, 5'd5}) begin n_fail++; $display("FAIL store_issue: got %b want 1000101", {bus.mem_issue, bus.alu_issue, bus.iss_dst}); end
    @(posedge clk); #1;
    n_checks++; if (bus.sb_busy !== 32'h0) begin n_fail++; $display("FAIL store_no_busy: got %h want 0", bus.sb_busy); end
    @(negedge clk); drive_head(C_ALU, 2'b10, 5, 0, 6); #1;
    n_checks++; if ({bus.stalling, bus.alu_issue} !== 2'b01) begin n_fail++; $display("FAIL store_dep_fire: got %b want 01", {bus.stalling, bus.alu_issue}); end
    @(posedge clk); #1;
    n_checks++; if (bus.sb_busy !== 32'h40) begin n_fail++; $display("FAIL store_sb6: got %h want 40", bus.sb_busy); end
    writeback(6);
  endtask

  task automatic test_set_clear();
    @(negedge clk); idle(); drive_head(C_ALU, 2'b11, 0, 0, 9); bus.wb_valid = 1'b1; bus.wb_dst = 5'd9; #1;
    n_checks++; if (bus.alu_issue !== 1'b1) begin n_fail++; $display("FAIL setclr_fire: got %b want 1", bus.alu_issue); end
    @(posedge clk); #1;
    n_checks++; if (bus.sb_busy !== 32'h200) begin n_fail++; $display("FAIL setclr_set_wins: got %h want 200", bus.sb_busy); end
    writeback(9);
    n_checks++; if (bus.sb_busy !== 32'h0) begin n_fail++; $display("FAIL setclr_clear: got %h want 0", bus.sb_busy); end
  endtask

  task automatic test_struct_stall();
    @(negedge clk); idle(); drive_head(C_ALU, 2'b11, 0, 0, 10); bus.alu_busy = 1'b1; #1;
    n_checks++; if ({bus.stalling, bus.alu_issue} !== 2'b10) begin n_fail++; $display("FAIL struct_alu_busy: got %b want 10", {bus.stalling, bus.alu_issue}); end
    @(posedge clk);
    @(negedge clk); bus.alu_busy = 1'b0; #1;
    n_checks++; if ({bus.stalling, bus.alu_issue, bus.iss_dst} !== {2'b01, 5'd10}) begin n_fail++; $display("FAIL struct_alu_free: got %b want 0101010", {bus.stalling, bus.alu_issue, bus.iss_dst}); end
    @(posedge clk);
    @(negedge clk); idle(); drive_head(C_LOAD, 2'b11, 0, 0, 11); bus.mem_busy = 1'b1; #1;
    n_checks++; if ({bus.stalling, bus.mem_issue} !== 2'b10) begin n_fail++; $display("FAIL struct_mem_busy: got %b want 10", {bus.stalling, bus.mem_issue}); end
    @(posedge clk); #1;
    n_checks++; if (bus.sb_busy !== 32'h400) begin n_fail++; $display("FAIL struct_sb: got %h want 400", bus.sb_busy); end
    writeback(10);
  endtask

  task automatic test_hazard_select();
    @(negedge clk); idle(); drive_head(C_ALU, 2'b11, 0, 0, 0); @(posedge clk);
    @(negedge clk); drive_head(C_ALU, 2'b11, 0, 0, 12); @(posedge clk); #1;
    n_checks++; if (bus.sb_busy !== 32'h1001) begin n_fail++; $display("FAIL hz_setup: got %h want 1001", bus.sb_busy); end
    @(negedge clk); drive_head(C_ALU, 2'b01, 12, 1, 13); #1;
    n_checks++; if (bus.alu_issue !== 1'b1) begin n_fail++; $display("FAIL hz_esc_src1: got %b want 1", bus.alu_issue); end
    @(posedge clk);
    @(negedge clk); drive_head(C_ALU, 2'b01, 1, 12, 14); #1;
    n_checks++; if ({bus.stalling, bus.alu_issue} !== 2'b10) begin n_fail++; $display("FAIL hz_src2: got %b want 10", {bus.stalling, bus.alu_issue}); end
    @(posedge clk);
    @(negedge clk); drive_head(C_MALU, 2'b11, 1, 1, 15); #1;
    n_checks++; if ({bus.stalling, bus.alu_issue} !== 2'b10) begin n_fail++; $display("FAIL hz_mask_reg0: got %b want 10", {bus.stalling, bus.alu_issue}); end
    @(posedge clk);
    @(negedge clk); drive_head(C_ALU, 2'b11, 1, 1, 15); #1;
    n_checks++; if ({bus.stalling, bus.alu_issue, bus.iss_masked} !== 3'b010) begin n_fail++; $display("FAIL hz_unmasked: got %b want 010", {bus.stalling, bus.alu_issue, bus.iss_masked}); end
    @(posedge clk);
    @(negedge clk); drive_head(C_NOP, 2'b00, 12, 12, 12); #1;
    n_checks++; if ({bus.stalling, bus.alu_issue, bus.mem_issue} !== 3'b000) begin n_fail++; $display("FAIL hz_nop: got %b want 000", {bus.stalling, bus.alu_issue, bus.mem_issue}); end
    @(posedge clk); #1;
    n_checks++; if (bus.sb_busy !== 32'hB001) begin n_fail++; $display("FAIL hz_sb: got %h want b001", bus.sb_busy); end
    writeback(0); writeback(12); writeback(13); writeback(15);
    n_checks++; if (bus.sb_busy !== 32'h0) begin n_fail++; $display("FAIL hz_cleanup: got %h want 0", bus.sb_busy); end
  endtask

  task automatic test_setvl_drain();
    logic [31:0] vsrc [5];
    logic [5:0]  vexp [5];
    vsrc = '{32'd5, 32'd0, 32'd33, 32'd31, 32'd9};
    vexp = '{6'd5, 6'd0, 6'd32, 6'd31, 6'd9};
    @(negedge clk); idle(); drive_head(C_LOAD, 2'b11, 0, 0, 7); #1;
    n_checks++; if (bus.mem_issue !== 1'b1) begin n_fail++; $display("FAIL sv_load_issue: got %b want 1", bus.mem_issue); end
    @(posedge clk);
    @(negedge clk); drive_head(C_SETVL, 2'b11, 0, 0, 0); bus.vl_src = 32'd100; bus.mem_busy = 1'b1; #1;
    n_checks++; if ({bus.stalling, bus.dbg_state} !== 3'b100) begin n_fail++; $display("FAIL sv_issue_stall: got %b want 100", {bus.stalling, bus.dbg_state}); end
    @(posedge clk); #1;
    n_checks++; if (bus.dbg_state !== 2'd1) begin n_fail++; $display("FAIL sv_enter_drain: got %0d want 1", bus.dbg_state); end
    @(negedge clk); bus.wb_valid = 1'b1; bus.wb_dst = 5'd7; #1;
    n_checks++; if (bus.stalling !== 1'b1) begin n_fail++; $display("FAIL sv_drain_stall: got %b want 1", bus.stalling); end
    @(posedge clk); #1;
    n_checks++; if ({bus.dbg_state, bus.sb_busy} !== {2'd1, 32'h0}) begin n_fail++; $display("FAIL sv_mem_busy_hold: got %0d/%h want 1/0", bus.dbg_state, bus.sb_busy); end
    @(negedge clk); bus.wb_valid = 1'b0; bus.mem_busy = 1'b0; #1;
    n_checks++; if (bus.stalling !== 1'b1) begin n_fail++; $display("FAIL sv_drain_exit_stall: got %b want 1", bus.stalling); end
    @(posedge clk); #1;
    n_checks++; if (bus.dbg_state !== 2'd2) begin n_fail++; $display("FAIL sv_enter_setvl: got %0d want 2", bus.dbg_state); end
    @(negedge clk); #1;
    n_checks++; if (bus.stalling !== 1'b0) begin n_fail++; $display("FAIL sv_consume: got %b want 0", bus.stalling); end
    @(posedge clk); #1;
    n_checks++; if ({bus.dbg_state, bus.vl} !== {2'd0, 6'd32}) begin n_fail++; $display("FAIL sv_vl_sat: got %0d/%0d want 0/32", bus.dbg_state, bus.vl); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); idle(); drive_head(C_SETVL, 2'b00, 0, 0, 0); bus.vl_src = vsrc[i];
      @(posedge clk); @(posedge clk); #1;
      n_checks++; if (bus.dbg_state !== 2'd2) begin n_fail++; $display("FAIL sv_min_latency[%0d]: got %0d want 2", i, bus.dbg_state); end
      @(posedge clk); #1;
      n_checks++; if (bus.vl !== vexp[i]) begin n_fail++; $display("FAIL sv_vl[%0d]: got %0d want %0d", i, bus.vl, vexp[i]); end
    end
    @(negedge clk); idle(); drive_head(C_ALU, 2'b11, 0, 0, 8); @(posedge clk);
    @(negedge clk); drive_head(C_SETVL, 2'b00, 0, 0, 0); bus.vl_src = 32'd20; @(posedge clk);
    @(negedge clk); idle(); #1;
    n_checks++; if (bus.stalling !== 1'b0) begin n_fail++; $display("FAIL sv_abort_stall: got %b want 0", bus.stalling); end
    @(posedge clk); #1;
    n_checks++; if ({bus.dbg_state, bus.vl} !== {2'd0, 6'd9}) begin n_fail++; $display("FAIL sv_abort: got %0d/%0d want 0/9", bus.dbg_state, bus.vl); end
    @(negedge clk); drive_head(C_SETVL, 2'b00, 0, 0, 0); bus.vl_src = 32'd20; @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    n_checks++; if ({bus.stalling, bus.dbg_state, bus.sb_busy, bus.vl} !== {1'b0, 2'd0, 32'h0, 6'd32}) begin n_fail++; $display("FAIL sv_reset_mid_drain: got %b/%0d/%h/%0d want 0/0/0/32", bus.stalling, bus.dbg_state, bus.sb_busy, bus.vl); end
    @(posedge clk);
    @(negedge clk); idle(); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    idle();
    test_reset();
    test_raw_chain();
    test_store();
    test_set_clear();
    test_struct_stall();
    test_hazard_select();
    test_setvl_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
